// File: rtl/mem_master_initiator.sv
// mem_master_initiator
//   Initiator end of the single-channel minimal memory interface. A client
//   hands over one read/write command at a time on a valid/ready handshake;
//   the block drives the bus until the responder strobes M_DataRdy, then
//   returns the size-masked read data on a one-cycle rsp_valid pulse.
//
//   Ports:
//     clock, reset        rising-edge clock, synchronous active-low reset
//     cmd_valid/ready     command handshake (ready only while idle)
//     cmd_we/addr/wdata/size   command fields (size in bits, 0 = full lane)
//     rsp_valid           one-cycle completion pulse
//     rsp_rdata           masked, zero-extended read data (0 for writes)
//     rsp_err             transaction aborted by timeout
//     Mout_*_ram          bus request outputs (oe/we/addr/Wdata/size)
//     M_Rdata_ram         responder read data
//     M_DataRdy           responder completion strobe
//
//   Optional feature: define MEM_TIMEOUT_EN to abort a request that has
//   waited TIMEOUT cycles for M_DataRdy. Without it the request waits
//   indefinitely and rsp_err is tied low.
module mem_master_initiator #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [SIZE_W-1:0] cmd_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

  state_t state_reg, state_next;

  logic              cmd_ready_reg, cmd_ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              oe_reg, oe_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [SIZE_W-1:0] size_reg, size_next;
  logic [DATA_W-1:0] mask_reg, mask_next;

`ifdef MEM_TIMEOUT_EN
  // At least 8 bits wide, wider only if TIMEOUT itself needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rsp_err_reg, rsp_err_next;
`endif

  // Effective access size: 0 or anything wider than the lane means full lane.
  logic [SIZE_W-1:0] cmd_eff;
  logic [DATA_W-1:0] cmd_mask;

  assign cmd_eff = ((cmd_size == '0) || (int'(cmd_size) > DATA_W)) ?
                   SIZE_W'(DATA_W) : cmd_size;

  // Lane bit gi survives the mask when it lies below the effective size.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign cmd_mask[gi] = (int'(cmd_eff) > gi);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      oe_reg        <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= '0;
      mask_reg      <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg       <= '0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      oe_reg        <= oe_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      size_reg      <= size_next;
      mask_reg      <= mask_next;
`ifdef MEM_TIMEOUT_EN
      cnt_reg       <= cnt_next;
      rsp_err_reg   <= rsp_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    oe_next        = oe_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    size_next      = size_reg;
    mask_next      = mask_reg;
`ifdef MEM_TIMEOUT_EN
    cnt_next       = cnt_reg;
    rsp_err_next   = 1'b0;
`endif

    unique case (state_reg)
      ST_IDLE: begin
        // cmd_ready_reg is low for the first cycle after reset release.
        if (cmd_valid && cmd_ready_reg) begin
          state_next = ST_REQ;
          oe_next    = !cmd_we;
          we_next    = cmd_we;
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata & cmd_mask;
          size_next  = cmd_eff;
          mask_next  = cmd_mask;
`ifdef MEM_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      ST_REQ: begin
        if (M_DataRdy) begin
          state_next     = ST_RSP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = oe_reg ? (M_Rdata_ram & mask_reg) : '0;
          oe_next        = 1'b0;
          we_next        = 1'b0;
          addr_next      = '0;
          wdata_next     = '0;
          size_next      = '0;
        end
`ifdef MEM_TIMEOUT_EN
        // This is the TIMEOUT-th request cycle without a response.
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next     = ST_RSP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
          oe_next        = 1'b0;
          we_next        = 1'b0;
          addr_next      = '0;
          wdata_next     = '0;
          size_next      = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      ST_RSP: begin
        // The response cycle doubles as the mandatory idle bus cycle.
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    cmd_ready_next = (state_next == ST_IDLE);
  end

  assign cmd_ready          = cmd_ready_reg;
  assign rsp_valid          = rsp_valid_reg;
  assign rsp_rdata          = rsp_rdata_reg;
  assign Mout_oe_ram        = oe_reg;
  assign Mout_we_ram        = we_reg;
  assign Mout_addr_ram      = addr_reg;
  assign Mout_Wdata_ram     = wdata_reg;
  assign Mout_data_ram_size = size_reg;
`ifdef MEM_TIMEOUT_EN
  assign rsp_err            = rsp_err_reg;
`else
  assign rsp_err            = 1'b0;
`endif

endmodule
